calc_bin2bcd: RTL and testbench

Downstream stage of the 8-bit calculator. Consumes the calculator result bus c and converts it to BCD digits with a sequential shift-add-3 (double-dabble) engine, one bit per cycle. The registered digits feed the display driver. A valid/done handshake frames each conversion.

---
 rtl/calc_pkg.sv | 23 ++
 rtl/calc_bin2bcd_bcd_add3.sv | 12 +
 rtl/calc_bin2bcd.sv | 117 +++++++++++
 tb/tb_calc_bin2bcd.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator BCD output stage.
// Holds FSM encoding, default sizes and digit-correction constants.
package calc_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NDIG  = 3;

    localparam logic [3:0] ADD3_THR = 4'd5;
    localparam logic [3:0] ADD3_OFS = 4'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/calc_bin2bcd_bcd_add3.sv
// Double-dabble digit correction: add 3 to any digit of 5 or more.
// Purely combinational; one instance per BCD digit.
module bcd_add3
    import calc_pkg::*;
(
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    assign d_o = (d_i >= ADD3_THR) ? d_i + ADD3_OFS : d_i;

endmodule

// File: rtl/calc_bin2bcd.sv
// Sequential binary-to-BCD converter, one shift per enabled cycle.
// Define CALC_SIGNED_EN for two's-complement input and a sgn port.
module calc_bin2bcd
    import calc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NDIG  = DEF_NDIG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enb,
    input  logic [WIDTH-1:0]  c,
    input  logic              c_vld,
    output logic              busy,
    output logic              done,
`ifdef CALC_SIGNED_EN
    output logic              sgn,
`endif
    output logic [4*NDIG-1:0] bcd
);

    localparam int BW = 4 * NDIG;
    localparam int CW = cnt_width(WIDTH);

    state_t           st_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_d;
    logic [BW-1:0]    scr_q;
    logic [BW-1:0]    scr_d;
    logic [BW-1:0]    corr;
    logic [BW-1:0]    bcd_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] mag;

    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        bcd_add3 u_add3 (
            .d_i (scr_q[4*g +: 4]),
            .d_o (corr[4*g +: 4])
        );
    end

    assign {scr_d, sh_d} = {corr, sh_q} << 1;

`ifdef CALC_SIGNED_EN
    logic sgn_p_q;
    logic sgn_q;

    // -c of the most negative value wraps to itself, which reads as its magnitude
    assign mag = c[WIDTH-1] ? -c : c;
    assign sgn = sgn_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sgn_p_q <= 1'b0;
            sgn_q   <= 1'b0;
        end else if (enb) begin
            if (st_q == S_IDLE && c_vld) begin
                sgn_p_q <= c[WIDTH-1];
            end
            if (st_q == S_DONE) begin
                sgn_q <= sgn_p_q;
            end
        end
    end
`else
    assign mag = c;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q   <= S_IDLE;
            cnt_q  <= '0;
            sh_q   <= '0;
            scr_q  <= '0;
            bcd_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (enb) begin
            unique case (st_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (c_vld) begin
                        sh_q   <= mag;
                        scr_q  <= '0;
                        cnt_q  <= CW'(WIDTH);
                        busy_q <= 1'b1;
                        st_q   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    scr_q <= scr_d;
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        st_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    bcd_q  <= scr_q;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    st_q   <= S_IDLE;
                end
                default: begin
                    st_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_calc_bin2bcd.sv
// Bench for calc_bin2bcd: vector table plus hand-written corner sequences.
// Build with CALC_SIGNED_EN to exercise the signed variant.
module tb_calc_bin2bcd;

    logic        clk = 1'b0;
    logic        rst;
    logic        enb;
    logic [7:0]  c;
    logic        c_vld;
    logic        busy;
    logic        done;
    logic        sgn;
    logic [11:0] bcd;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic done_prev = 1'b0;
    logic [12:0] sb[$];

    typedef struct {
        logic [7:0]  v;
        logic        es;
        logic [11:0] eb;
    } vec_t;

    always #5 clk = ~clk;

    calc_bin2bcd dut (
        .clk   (clk),
        .rst   (rst),
        .enb   (enb),
        .c     (c),
        .c_vld (c_vld),
        .busy  (busy),
        .done  (done),
`ifdef CALC_SIGNED_EN
        .sgn   (sgn),
`endif
        .bcd   (bcd)
    );

`ifndef CALC_SIGNED_EN
    assign sgn = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [12:0] model(input logic [7:0] v);
        int m;
        logic s;
        m = int'(v);
        s = 1'b0;
`ifdef CALC_SIGNED_EN
        if (v[7]) begin
            s = 1'b1;
            m = 256 - m;
        end
`endif
        return {s, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] v, input bit expect_acc);
        c = v;
        c_vld = 1'b1;
        if (expect_acc) sb.push_back(model(v));
        step();
        c_vld = 1'b0;
        c = $urandom_range(255);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            step();
            n++;
        end
        if (!done) begin
            bad++;
            total++;
            $display("FAIL done_timeout act=0 exp=1 t=%0t", $time);
        end
    endtask

    always @(negedge clk) begin
        if (done && !done_prev) begin
            done_cnt++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected_done act=%0h exp=none", bcd);
            end else begin
                logic [12:0] e;
                e = sb.pop_front();
                chk("sb_bcd", 32'(bcd), 32'(e[11:0]));
                chk("sb_sgn", 32'(sgn), 32'(e[12]));
            end
        end
        done_prev = done;
    end

    initial begin
        vec_t vt[$];
        int n;
        int dc;
        logic [11:0] hb;

`ifdef CALC_SIGNED_EN
        vt = '{
            '{8'hF6, 1'b1, 12'h010}, '{8'h80, 1'b1, 12'h128},
            '{8'h7F, 1'b0, 12'h127}, '{8'hFF, 1'b1, 12'h001},
            '{8'h00, 1'b0, 12'h000}, '{8'h01, 1'b0, 12'h001},
            '{8'h9C, 1'b1, 12'h100}, '{8'h64, 1'b0, 12'h100}
        };
`else
        vt = '{
            '{8'd0,   1'b0, 12'h000}, '{8'd1,   1'b0, 12'h001},
            '{8'd9,   1'b0, 12'h009}, '{8'd10,  1'b0, 12'h010},
            '{8'd99,  1'b0, 12'h099}, '{8'd100, 1'b0, 12'h100},
            '{8'd127, 1'b0, 12'h127}, '{8'd199, 1'b0, 12'h199},
            '{8'd250, 1'b0, 12'h250}, '{8'd255, 1'b0, 12'h255}
        };
`endif

        rst = 1'b0;
        enb = 1'b1;
        c = 8'd0;
        c_vld = 1'b0;
        step();
        step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_bcd", 32'(bcd), 0);
        chk("rst_sgn", 32'(sgn), 0);
        rst = 1'b1;
        step();

        // 255: busy across the shift phase, done on edge 9
        pulse(8'd255, 1'b1);
        chk("t1_busy0", 32'(busy), 1);
        for (int i = 1; i <= 9; i++) begin
            step();
            if (i < 9) begin
                chk("t1_busy", 32'(busy), 1);
                chk("t1_nodone", 32'(done), 0);
            end else begin
                chk("t1_done", 32'(done), 1);
                chk("t1_busy_end", 32'(busy), 0);
                chk("t1_bcd", 32'(bcd), 32'(model(8'd255)));
            end
        end
        step();
        chk("t1_pulse_len", 32'(done), 0);

        // 0 then 99 accepted on the done cycle
        pulse(8'd0, 1'b1);
        wait_done(n);
        chk("t2_lat0", n, 9);
        chk("t2_bcd0", 32'(bcd), 32'h000);
        pulse(8'd99, 1'b1);
        wait_done(n);
        chk("t2_lat99", n, 9);
        chk("t2_bcd99", 32'(bcd), 32'(model(8'd99)));
        step();

        // 128 with a 3-cycle stall mid-shift
        pulse(8'd128, 1'b1);
        step();
        step();
        step();
        enb = 1'b0;
        hb = bcd;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_hold_busy", 32'(busy), 1);
            chk("t3_hold_done", 32'(done), 0);
            chk("t3_hold_bcd", 32'(bcd), 32'(hb));
        end
        enb = 1'b1;
        wait_done(n);
        chk("t3_lat", 6 + n, 12);
        chk("t3_bcd", 32'(bcd), 32'(model(8'd128)));
        enb = 1'b0;
        step();
        step();
        chk("t3_done_held", 32'(done), 1);
        enb = 1'b1;
        step();
        chk("t3_done_clr", 32'(done), 0);

        // 7 pulsed while busy must be dropped
        dc = done_cnt;
        pulse(8'd200, 1'b1);
        step();
        step();
        pulse(8'd7, 1'b0);
        wait_done(n);
        chk("t4_bcd", 32'(bcd), 32'(model(8'd200)));
        for (int i = 0; i < 12; i++) step();
        chk("t4_one_done", done_cnt - dc, 1);

        // reset mid-conversion aborts
        pulse(8'd77, 1'b1);
        step();
        step();
        step();
        dc = done_cnt;
        rst = 1'b0;
        sb.delete();
        #1;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_done", 32'(done), 0);
        chk("t5_bcd", 32'(bcd), 0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 12; i++) step();
        chk("t5_no_done", done_cnt - dc, 0);
        pulse(8'd42, 1'b1);
        wait_done(n);
        chk("t5_bcd42", 32'(bcd), 32'(model(8'd42)));
        step();

        foreach (vt[i]) begin
            pulse(vt[i].v, 1'b1);
            wait_done(n);
            chk("tab_lat", n, 9);
            chk("tab_bcd", 32'(bcd), 32'(vt[i].eb));
            chk("tab_sgn", 32'(sgn), 32'(vt[i].es));
            step();
        end

        step();
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
